// File: rtl/store_write_buffer.sv
// Posted-write buffer between the datapath store port and data memory.
// Optional sub-word lane steering: define STORE_BYTE_LANES_EN.
module store_write_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       MemWrite,
    input  logic                       MemRead,
    input  logic [AW-1:0]              ALUResult,
    input  logic [DW-1:0]              WriteData,
    input  logic [1:0]                 StoreSize,
    output logic                       Stall,
    output logic                       LoadHazard,
    output logic                       Empty,
    output logic [$clog2(DEPTH+1)-1:0] Count,
    output logic                       mem_valid,
    output logic [AW-1:0]              mem_addr,
    output logic [DW-1:0]              mem_wdata,
    output logic [3:0]                 mem_be,
    input  logic                       mem_ready
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [3:0]    be_q   [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          full_c;
    logic          push_c;
    logic          pop_c;
    logic [AW-1:0] ent_addr_c;
    logic [DW-1:0] ent_data_c;
    logic [3:0]    ent_be_c;
    logic          unused_c;

    // Address low bits and size only matter when lane steering is built in.
    assign unused_c = ^{StoreSize, ALUResult[1:0]};

    assign full_c = (count_q == CW'(DEPTH));
    assign push_c = MemWrite && !full_c;
    assign pop_c  = mem_valid && mem_ready;

    // Format the incoming store into an entry.
    always_comb begin
        ent_addr_c = {ALUResult[AW-1:2], 2'b00};
        ent_data_c = WriteData;
        ent_be_c   = 4'b1111;
`ifdef STORE_BYTE_LANES_EN
        case (StoreSize)
            2'b00: begin
                ent_be_c   = 4'b0001 << ALUResult[1:0];
                ent_data_c = {4{WriteData[7:0]}};
            end
            2'b01: begin
                ent_be_c   = ALUResult[1] ? 4'b1100 : 4'b0011;
                ent_data_c = {2{WriteData[15:0]}};
            end
            default: begin
                ent_be_c   = 4'b1111;
                ent_data_c = WriteData;
            end
        endcase
`endif
    end

    // Pointer and occupancy next-state.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (push_c) begin
                addr_q[wr_ptr_q]  <= ent_addr_c;
                data_q[wr_ptr_q]  <= ent_data_c;
                be_q[wr_ptr_q]    <= ent_be_c;
                valid_q[wr_ptr_q] <= 1'b1;
            end
            // Push and pop never target the same slot: that needs empty or full.
            if (pop_c) begin
                valid_q[rd_ptr_q] <= 1'b0;
            end
        end
    end

    // Any queued store to the same word blocks the load, including the one popping now.
    always_comb begin
        LoadHazard = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (valid_q[i] && (addr_q[i][AW-1:2] == ALUResult[AW-1:2])) begin
                LoadHazard = MemRead;
            end
        end
    end

    assign Stall     = MemWrite && full_c;
    assign Empty     = (count_q == '0);
    assign Count     = count_q;
    assign mem_valid = !Empty;
    assign mem_addr  = Empty ? '0 : addr_q[rd_ptr_q];
    assign mem_wdata = Empty ? '0 : data_q[rd_ptr_q];
    assign mem_be    = Empty ? '0 : be_q[rd_ptr_q];

endmodule
